// File: rtl/status_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_display_pkg
// Description : Shared constants for the status display: FSM state codes,
//               active-low seven-segment glyphs ({g,f,e,d,c,b,a}), DigitMode
//               encodings and the status-glyph selection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package status_display_pkg;

  // FSM state encoding (also the value driven on the State output)
  typedef logic [1:0] state_t;
  localparam state_t ST_LAMP   = 2'b00;
  localparam state_t ST_RUN    = 2'b01;
  localparam state_t ST_LOCKED = 2'b10;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_ALL_ON = 7'b0000000;
  localparam logic [6:0] SEG_O      = 7'b0100011;
  localparam logic [6:0] SEG_D      = 7'b0100001;
  localparam logic [6:0] SEG_R      = 7'b0101111;
  localparam logic [6:0] SEG_L      = 7'b1000111;

  // Per-digit DigitMode encodings
  localparam logic [1:0] MODE_BLANK     = 2'b00;
  localparam logic [1:0] MODE_HEX       = 2'b01;
  localparam logic [1:0] MODE_STATUS    = 2'b10;
  localparam logic [1:0] MODE_BLANK_ALT = 2'b11;

  // Status glyph for a digit position: each of the first four digits shows
  // one indicator; higher digits have no indicator and stay blank.
  function automatic logic [6:0] status_glyph(input int   idx,
                                              input logic hb,
                                              input logic dv,
                                              input logic run,
                                              input logic locked);
    logic [6:0] g;
    g = SEG_BLANK;
    case (idx)
      0:       g = hb     ? SEG_O : SEG_BLANK;
      1:       g = dv     ? SEG_D : SEG_BLANK;
      2:       g = run    ? SEG_R : SEG_BLANK;
      3:       g = locked ? SEG_L : SEG_BLANK;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/status_display_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational hex nibble to active-low seven-segment decoder.
// Ports       : nibble - 4-bit hex value
//               seg    - active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/status_display.sv
`default_nettype none
// ============================================================================
// Module      : status_display
// Description : Multi-digit seven-segment status display. Shows per-digit hex
//               values or status glyphs (heartbeat, stretched data-valid,
//               running, locked), blinks the whole display while LOCKED.
//               Optional lamp test enabled by STATUS_DISPLAY_LAMP_TEST_EN.
// Ports       : HCLK, HRESET (sync, active high), DataValid, LOCKUP,
//               Value[4*N], DigitMode[2*N] -> HEX[7*N] (active low,
//               registered), Heartbeat, State[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module status_display
  import status_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int HB_MSB         = 25,
  parameter int STRETCH_CYCLES = 2500000,
  parameter int LAMP_CYCLES    = 50000000
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    DataValid,
  input  logic                    LOCKUP,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [2*NUM_DIGITS-1:0] DigitMode,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic                    Heartbeat,
  output logic [1:0]              State
);

  localparam int                STR_W    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [STR_W-1:0]  STR_LOAD = STR_W'(STRETCH_CYCLES);
  localparam logic [STR_W-1:0]  STR_ONE  = {{(STR_W-1){1'b0}}, 1'b1};
  localparam logic [HB_MSB:0]   TICK_ONE = {{HB_MSB{1'b0}}, 1'b1};
  localparam logic [7*NUM_DIGITS-1:0] HEX_BLANK = {NUM_DIGITS{SEG_BLANK}};

`ifdef STATUS_DISPLAY_LAMP_TEST_EN
  localparam state_t ST_RESET = ST_LAMP;
`else
  localparam state_t ST_RESET = ST_RUN;
`endif

  logic [HB_MSB:0]           tick_q,    tick_d;
  logic                      hb_q,      hb_d;
  logic                      running_q, running_d;
  logic [STR_W-1:0]          stretch_q, stretch_d;
  state_t                    state_q,   state_d;
  logic [7*NUM_DIGITS-1:0]   hex_q,     hex_d;
  logic                      dv_ind;
  logic                      locked;
  logic [6:0]                glyph;
  logic [NUM_DIGITS-1:0][6:0] seg_w;

  // One hex decoder per digit
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    seg7_decode u_dec (
      .nibble (Value[4*gi +: 4]),
      .seg    (seg_w[gi])
    );
  end

  assign dv_ind = (stretch_q != '0);
  assign locked = (state_q == ST_LOCKED);

  always_comb begin
    tick_d    = tick_q + TICK_ONE;
    hb_d      = tick_q[HB_MSB] & tick_q[HB_MSB-2];
    running_d = 1'b1;
    // A fresh DataValid always wins over the countdown so retriggers are gapless
    if (DataValid)
      stretch_d = STR_LOAD;
    else if (dv_ind)
      stretch_d = stretch_q - STR_ONE;
    else
      stretch_d = stretch_q;
  end

`ifdef STATUS_DISPLAY_LAMP_TEST_EN
  localparam int               LAMP_W    = $clog2(LAMP_CYCLES + 1);
  localparam logic [LAMP_W-1:0] LAMP_LAST = LAMP_W'(LAMP_CYCLES - 1);
  localparam logic [LAMP_W-1:0] LAMP_ONE  = {{(LAMP_W-1){1'b0}}, 1'b1};

  logic [LAMP_W-1:0] lamp_cnt_q, lamp_cnt_d;
  logic              lamp_lock_q, lamp_lock_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      lamp_cnt_q  <= '0;
      lamp_lock_q <= 1'b0;
    end else begin
      lamp_cnt_q  <= lamp_cnt_d;
      lamp_lock_q <= lamp_lock_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
`ifdef STATUS_DISPLAY_LAMP_TEST_EN
    lamp_cnt_d  = lamp_cnt_q;
    lamp_lock_d = lamp_lock_q;
`endif
    case (state_q)
      ST_LAMP: begin
`ifdef STATUS_DISPLAY_LAMP_TEST_EN
        // A LOCKUP seen during lamp test is remembered, not acted on early
        lamp_lock_d = lamp_lock_q | LOCKUP;
        if (lamp_cnt_q == LAMP_LAST)
          state_d = (lamp_lock_q | LOCKUP) ? ST_LOCKED : ST_RUN;
        else
          lamp_cnt_d = lamp_cnt_q + LAMP_ONE;
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN:    if (LOCKUP) state_d = ST_LOCKED;
      ST_LOCKED: state_d = ST_LOCKED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    hex_d = HEX_BLANK;
    glyph = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      case (DigitMode[2*i +: 2])
        MODE_HEX:    glyph = seg_w[i];
        MODE_STATUS: glyph = status_glyph(i, hb_q, dv_ind, running_q, locked);
        default:     glyph = SEG_BLANK;
      endcase
      // Blink: blank during the low half of tick[HB_MSB-1]
      if (locked && !tick_q[HB_MSB-1])
        glyph = SEG_BLANK;
`ifdef STATUS_DISPLAY_LAMP_TEST_EN
      if (state_q == ST_LAMP)
        glyph = SEG_ALL_ON;
`endif
      hex_d[7*i +: 7] = glyph;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tick_q    <= '0;
      hb_q      <= 1'b0;
      running_q <= 1'b0;
      stretch_q <= '0;
      state_q   <= ST_RESET;
      hex_q     <= HEX_BLANK;
    end else begin
      tick_q    <= tick_d;
      hb_q      <= hb_d;
      running_q <= running_d;
      stretch_q <= stretch_d;
      state_q   <= state_d;
      hex_q     <= hex_d;
    end
  end

  assign HEX       = hex_q;
  assign Heartbeat = hb_q;
  assign State     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_status_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_display
// Description : Directed self-checking bench for status_display with
//               NUM_DIGITS=4, HB_MSB=4, STRETCH_CYCLES=3, LAMP_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_display;

  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] GO  = 7'b0100011;
  localparam logic [6:0] GD  = 7'b0100001;
  localparam logic [6:0] GR  = 7'b0101111;
  localparam logic [6:0] GL  = 7'b1000111;
  localparam logic [6:0] H1  = 7'b1111001;
  localparam logic [6:0] H2  = 7'b0100100;
  localparam logic [6:0] H3  = 7'b0110000;
  localparam logic [6:0] H4  = 7'b0011001;
`ifdef STATUS_DISPLAY_LAMP_TEST_EN
  localparam bit LAMP = 1'b1;
`else
  localparam bit LAMP = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET, DataValid, LOCKUP;
  logic [15:0] Value;
  logic [7:0]  DigitMode;
  logic [27:0] HEX;
  logic        Heartbeat;
  logic [1:0]  State;

  int errors = 0;
  int checks = 0;
  int tick_m = 0;     // expected tick value after the latest edge
  int tick_prev = 0;  // tick value before the latest edge

  status_display #(
    .NUM_DIGITS(4), .HB_MSB(4), .STRETCH_CYCLES(3), .LAMP_CYCLES(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .DataValid(DataValid), .LOCKUP(LOCKUP),
    .Value(Value), .DigitMode(DigitMode), .HEX(HEX),
    .Heartbeat(Heartbeat), .State(State)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    tick_prev = tick_m;
    tick_m = HRESET ? 0 : (tick_m + 1) % 32;
    #1;
  endtask

  function automatic bit hb_of(input int t);
    int m;
    m = t % 32;
    return ((m >= 20 && m <= 23) || (m >= 28));
  endfunction

  function automatic logic [27:0] pack(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  bit          dv1 [6] = '{1, 0, 0, 0, 0, 0};
  bit          ex1 [6] = '{0, 1, 1, 1, 0, 0};
  bit          dv2 [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
  bit          ex2 [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
  logic [27:0] exp_hex;
  bit          lk_prev, dv_prev;

  initial begin
    HRESET = 1'b1; DataValid = 1'b0; LOCKUP = 1'b0;
    Value = 16'h4321; DigitMode = 8'h55;
    repeat (3) step();
    check("reset_hex", HEX, {28{1'b1}});
    check("reset_hb", Heartbeat, 0);
    check("reset_state", State, LAMP ? 2'b00 : 2'b01);

    // First cycle after reset: hex mode on all digits
    HRESET = 1'b0;
    step();
    check("hex_4321", HEX, LAMP ? 28'h0 : pack(H4, H3, H2, H1));

    // Free run with status glyphs: heartbeat timing and o/r glyphs
    DigitMode = 8'hAA;
    for (int k = 2; k <= 40; k++) begin
      step();
      check("heartbeat", Heartbeat, hb_of(k - 1));
      check("state_run", State, (LAMP && k <= 7) ? 2'b00 : 2'b01);
      exp_hex = (LAMP && k <= 8) ? 28'h0 : pack(BL, GR, BL, hb_of(k - 2) ? GO : BL);
      check("status_glyphs", HEX, exp_hex);
    end

    // DataValid stretch: single pulse, then retrigger
    DigitMode = 8'h08;
    for (int j = 0; j < 6; j++) begin
      DataValid = dv1[j];
      step();
      check("dv_single", HEX, pack(BL, BL, ex1[j] ? GD : BL, BL));
    end
    for (int j = 0; j < 8; j++) begin
      DataValid = dv2[j];
      step();
      check("dv_retrig", HEX, pack(BL, BL, ex2[j] ? GD : BL, BL));
    end

    // Simultaneous DataValid + LOCKUP pulse, then blink while locked
    DigitMode = 8'h89;
    for (int j = 0; j < 24; j++) begin
      DataValid = (j == 0);
      LOCKUP    = (j == 0);
      step();
      lk_prev = (j >= 1);
      dv_prev = (j >= 1 && j <= 3);
      check("locked_state", State, 2'b10);
      if (lk_prev && ((tick_prev >> 3) & 1) == 0)
        exp_hex = {28{1'b1}};
      else
        exp_hex = pack(lk_prev ? GL : BL, BL, dv_prev ? GD : BL, H1);
      check("locked_hex", HEX, exp_hex);
    end

    // Reset out of LOCKED
    HRESET = 1'b1;
    step();
    check("relock_rst_hex", HEX, {28{1'b1}});
    check("relock_rst_state", State, LAMP ? 2'b00 : 2'b01);
    check("relock_rst_hb", Heartbeat, 0);
    HRESET = 1'b0;
    step();
    check("after_rst_state", State, LAMP ? 2'b00 : 2'b01);

`ifdef STATUS_DISPLAY_LAMP_TEST_EN
    // LOCKUP during lamp test takes effect on lamp exit
    for (int k = 2; k <= 9; k++) begin
      LOCKUP = (k == 3);
      step();
      check("lamp_lock_state", State, (k <= 7) ? 2'b00 : 2'b10);
    end
    LOCKUP = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
